// File: rtl/usb_rx_fifo_reader_pkg.sv
// rtl/usb_rx_fifo_reader_pkg.sv - shared FX2 endpoint addresses and reader state encoding
package usb_rx_fifo_reader_pkg;

  localparam logic [1:0] EP2_ADDR = 2'b00;
  localparam logic [1:0] EP4_ADDR = 2'b01;
  localparam logic [1:0] EP6_ADDR = 2'b10;
  localparam logic [1:0] EP8_ADDR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_RD    = 3'd2,
    S_GAP   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } rd_state_t;

endpackage

// File: rtl/usb_rx_buf.sv
// rtl/usb_rx_buf.sv - small circular word buffer between the FX2 read side and the write stream
module usb_rx_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_valid,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop_ready,
  output logic                       pop_valid,
  output logic [DATA_W-1:0]          pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  assign do_push   = push_valid && (count_q != CW'(DEPTH));
  assign do_pop    = pop_ready && (count_q != '0);
  assign pop_valid = (count_q != '0);
  // Head is zeroed while empty so the stream reads 0 after reset and between bursts.
  assign pop_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/usb_rx_fifo_reader.sv
// rtl/usb_rx_fifo_reader.sv - FX2 slave-FIFO EP2 OUT reader feeding a valid/ready word stream
module usb_rx_fifo_reader
  import usb_rx_fifo_reader_pkg::*;
#(
  parameter logic [1:0] RX_FIFOADDR = EP2_ADDR,
  parameter int         CNT_W       = 24
) (
  input  logic             cyp_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] xfer_words,
  input  logic             usb_flaga,
  input  logic [15:0]      usb_fd_in,
  output logic [1:0]       usb_fifoaddr,
  output logic             usb_slcs,
  output logic             usb_sloe,
  output logic             usb_slrd,
  output logic             usb_slwr,
  output logic [15:0]      wr_data,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic             busy,
  output logic             download_done,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int BUF_DEPTH = 4;

  rd_state_t        state_q;
  logic [CNT_W-1:0] len_q, cnt_q;
  logic             slcs_q, sloe_q, slrd_q, busy_q, done_q;
  logic [2:0]       buf_count;
  logic             can_read, push;

  // The strobe is registered, so the read decision is made one cycle ahead
  // using the occupancy seen now; two free entries cover the in-flight word.
  assign can_read = usb_flaga && (buf_count <= 3'(BUF_DEPTH-2));
  assign push     = (state_q == S_RD) && !slrd_q;

  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      slcs_q  <= 1'b1;
      sloe_q  <= 1'b1;
      slrd_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q  <= xfer_words;
            cnt_q  <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b1;
            if (xfer_words == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_SEL;
              slcs_q  <= 1'b0;
              sloe_q  <= 1'b0;
            end
          end
        end
        S_SEL: begin
          state_q <= S_RD;
          slrd_q  <= !can_read;
        end
        S_RD: begin
          if (!slrd_q) begin
            slrd_q  <= 1'b1;
            state_q <= S_GAP;
            if (cnt_q != len_q) cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            slrd_q <= !can_read;
          end
        end
        S_GAP: begin
          if (cnt_q == len_q) begin
            state_q <= S_DRAIN;
            slcs_q  <= 1'b1;
            sloe_q  <= 1'b1;
          end else begin
            state_q <= S_RD;
            slrd_q  <= !can_read;
          end
        end
        S_DRAIN: begin
          if (buf_count == '0) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          slcs_q  <= 1'b1;
          sloe_q  <= 1'b1;
          slrd_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  usb_rx_buf #(
    .DATA_W (16),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk        (cyp_clk),
    .rst_n      (rst_n),
    .push_valid (push),
    .push_data  (usb_fd_in),
    .pop_ready  (wr_ready),
    .pop_valid  (wr_valid),
    .pop_data   (wr_data),
    .count      (buf_count)
  );

  assign usb_fifoaddr  = RX_FIFOADDR;
  assign usb_slcs      = slcs_q;
  assign usb_sloe      = sloe_q;
  assign usb_slrd      = slrd_q;
  assign usb_slwr      = 1'b1;
  assign busy          = busy_q;
  assign download_done = done_q;
  assign word_cnt      = cnt_q;

endmodule

// File: tb/tb_usb_rx_fifo_reader.sv
// tb/tb_usb_rx_fifo_reader.sv - bench for usb_rx_fifo_reader with FX2 source and stream sink models
module tb_usb_rx_fifo_reader;

  localparam int CNT_W = 24;

  logic             cyp_clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] xfer_words;
  logic             usb_flaga;
  logic [15:0]      usb_fd_in;
  logic [1:0]       usb_fifoaddr;
  logic             usb_slcs, usb_sloe, usb_slrd, usb_slwr;
  logic [15:0]      wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic             busy, download_done;
  logic [CNT_W-1:0] word_cnt;

  int checks = 0;
  int failures = 0;

  logic [15:0] src_mem [512];
  logic [15:0] rx_log  [512];
  int          strobe_cyc [512];
  int src_idx = 0, src_avail = 0, adv_cnt = 0;
  int rx_n = 0, strobe_n = 0, cyc = 0, last_strobe = 0;
  bit have_last = 0, stall_prev = 0;
  int occ = 0, max_occ = 0, gap_err = 0, proto_err = 0, stab_err = 0;
  logic [15:0] data_prev = '0;
  int s0, r0, t0;

  usb_rx_fifo_reader #(.RX_FIFOADDR(2'b00), .CNT_W(CNT_W)) dut (
    .cyp_clk       (cyp_clk),
    .rst_n         (rst_n),
    .start         (start),
    .xfer_words    (xfer_words),
    .usb_flaga     (usb_flaga),
    .usb_fd_in     (usb_fd_in),
    .usb_fifoaddr  (usb_fifoaddr),
    .usb_slcs      (usb_slcs),
    .usb_sloe      (usb_sloe),
    .usb_slrd      (usb_slrd),
    .usb_slwr      (usb_slwr),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .busy          (busy),
    .download_done (download_done),
    .word_cnt      (word_cnt)
  );

  always #5 cyp_clk = ~cyp_clk;

  function automatic logic [8:0] ix(input int v);
    return v[8:0];
  endfunction

  // FX2 endpoint model: host has queued words up to src_avail; a strobe consumes the head.
  assign usb_flaga = (src_idx < src_avail);
  assign usb_fd_in = src_mem[ix(src_idx)];

  always @(negedge cyp_clk) begin
    cyc++;
    if (usb_slwr !== 1'b1 || usb_fifoaddr !== 2'b00) proto_err++;
    if (rst_n !== 1'b1) begin
      occ = 0;
      have_last = 0;
      stall_prev = 0;
    end else begin
      if (usb_slrd === 1'b0) begin
        if (usb_slcs !== 1'b0 || usb_sloe !== 1'b0 || usb_flaga !== 1'b1) proto_err++;
        if (have_last && (cyc - last_strobe) < 2) gap_err++;
        strobe_cyc[ix(strobe_n)] = cyc;
        strobe_n++;
        last_strobe = cyc;
        have_last = 1;
        adv_cnt++;
        occ++;
      end
      if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
        rx_log[ix(rx_n)] = wr_data;
        rx_n++;
        occ--;
      end
      if (stall_prev && wr_valid === 1'b1 && wr_data !== data_prev) stab_err++;
      if (occ > max_occ) max_occ = occ;
      stall_prev = (wr_valid === 1'b1) && (wr_ready !== 1'b1);
      data_prev = wr_data;
    end
  end

  always @(posedge cyp_clk) begin
    #1;
    src_idx = adv_cnt;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic prep(input int n, input bit fixed);
    s0 = src_idx;
    r0 = rx_n;
    t0 = strobe_n;
    for (int i = 0; i < n; i++)
      src_mem[ix(s0 + i)] = fixed ? 16'((i + 1) * 16'h1111) : 16'($urandom_range(0, 65535));
    src_avail = s0 + n;
  endtask

  task automatic do_start(input int n);
    @(posedge cyp_clk); #1;
    xfer_words = CNT_W'(n);
    start = 1'b1;
    @(posedge cyp_clk); #1;
    start = 1'b0;
  endtask

  task automatic run_done(input string tag, input bit rnd);
    int k;
    k = 0;
    while (k < 2000 && !(busy === 1'b0 && download_done === 1'b1)) begin
      @(posedge cyp_clk); #1;
      if (rnd) wr_ready = 1'($urandom_range(0, 1));
      k++;
    end
    check({tag, "_finished"}, 32'(busy === 1'b0 && download_done === 1'b1), 32'd1);
  endtask

  task automatic verify(input string tag, input int n);
    check({tag, "_strobes"}, 32'(strobe_n - t0), 32'(n));
    check({tag, "_words_out"}, 32'(rx_n - r0), 32'(n));
    for (int i = 0; i < n; i++)
      check({tag, "_data"}, 32'(rx_log[ix(r0 + i)]), 32'(src_mem[ix(s0 + i)]));
    check({tag, "_word_cnt"}, 32'(word_cnt), 32'(n));
    check({tag, "_done"}, 32'(download_done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n, k;
    rst_n = 1'b0;
    start = 1'b0;
    xfer_words = '0;
    wr_ready = 1'b0;
    repeat (3) @(posedge cyp_clk);
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(download_done), 32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_strobes", 32'({usb_slcs, usb_sloe, usb_slrd, usb_slwr}), 32'hF);
    check("rst_fifoaddr", 32'(usb_fifoaddr), 32'd0);
    @(posedge cyp_clk); #1;
    rst_n = 1'b1;

    // Four fixed words, sink always ready: strobes two cycles apart.
    prep(4, 1'b1);
    wr_ready = 1'b1;
    do_start(4);
    run_done("basic", 1'b0);
    verify("basic", 4);
    for (int i = 0; i < 3; i++)
      check("basic_strobe_gap", 32'(strobe_cyc[ix(t0 + i + 1)] - strobe_cyc[ix(t0 + i)]), 32'd2);

    // Zero-length download goes straight to DONE.
    prep(0, 1'b0);
    do_start(0);
    check("zero_busy_in_done", 32'(busy), 32'd1);
    check("zero_done_cleared", 32'(download_done), 32'd0);
    @(posedge cyp_clk); #1;
    check("zero_done", 32'(download_done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_strobes", 32'(strobe_n - t0), 32'd0);
    check("zero_word_cnt", 32'(word_cnt), 32'd0);

    // Sink stalled: three words fit while one entry stays free.
    prep(8, 1'b0);
    wr_ready = 1'b0;
    do_start(8);
    repeat (30) @(posedge cyp_clk);
    #1;
    check("stall_strobes", 32'(strobe_n - t0), 32'd3);
    check("stall_word_cnt", 32'(word_cnt), 32'd3);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_valid", 32'(wr_valid), 32'd1);
    check("stall_head", 32'(wr_data), 32'(src_mem[ix(s0)]));
    wr_ready = 1'b1;
    run_done("stall", 1'b0);
    verify("stall", 8);

    // Host runs dry after two of five words, then supplies the rest.
    prep(5, 1'b0);
    src_avail = s0 + 2;
    wr_ready = 1'b1;
    do_start(5);
    repeat (20) @(posedge cyp_clk);
    #1;
    check("empty_strobes", 32'(strobe_n - t0), 32'd2);
    check("empty_slrd", 32'(usb_slrd), 32'd1);
    check("empty_busy", 32'(busy), 32'd1);
    check("empty_word_cnt", 32'(word_cnt), 32'd2);
    src_avail = s0 + 5;
    run_done("empty", 1'b0);
    verify("empty", 5);

    // A second start while busy must not restart the count.
    prep(6, 1'b0);
    wr_ready = 1'b1;
    do_start(6);
    k = 0;
    while (k < 100 && (strobe_n - t0) < 2) begin
      @(posedge cyp_clk); #1;
      k++;
    end
    check("restart_reached", 32'(strobe_n - t0 >= 2), 32'd1);
    do_start(10);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_cnt_kept", 32'(word_cnt >= 2), 32'd1);
    run_done("restart", 1'b0);
    verify("restart", 6);

    // Reset in the middle of the third read strobe.
    prep(6, 1'b0);
    wr_ready = 1'b0;
    do_start(6);
    k = 0;
    while (k < 200 && !(usb_slrd === 1'b0 && (strobe_n - t0) >= 2)) begin
      @(posedge cyp_clk); #2;
      k++;
    end
    check("midrst_reached", 32'(usb_slrd === 1'b0), 32'd1);
    check("midrst_valid_before", 32'(wr_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_strobes", 32'({usb_slcs, usb_sloe, usb_slrd, usb_slwr}), 32'hF);
    check("midrst_valid", 32'(wr_valid), 32'd0);
    check("midrst_word_cnt", 32'(word_cnt), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge cyp_clk);
    #1;
    rst_n = 1'b1;
    t0 = strobe_n;
    repeat (10) @(posedge cyp_clk);
    #1;
    check("midrst_quiet", 32'(strobe_n - t0), 32'd0);
    prep(6, 1'b0);
    do_start(6);
    run_done("fresh", 1'b1);
    verify("fresh", 6);

    // Randomized lengths with a randomly throttled sink.
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(1, 12);
      prep(n, 1'b0);
      wr_ready = 1'($urandom_range(0, 1));
      do_start(n);
      run_done("random", 1'b1);
      verify("random", n);
    end

    check("max_occupancy_ok", 32'(max_occ <= 3), 32'd1);
    check("strobe_gap_errors", 32'(gap_err), 32'd0);
    check("protocol_errors", 32'(proto_err), 32'd0);
    check("stability_errors", 32'(stab_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
